// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and the nibble validity check used by the
// N-digit BCD counter and its per-digit register.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // True when the nibble is a legal decimal digit (0..9).
    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One BCD digit register of the N-digit counter.
// Steps up or down when its carry/borrow input is high. It reports
// combinationally when it sits at its limit (9 counting up, 0 counting down)
// with an incoming carry/borrow, so the next digit can ripple.
// A load replaces the digit with the supplied nibble; an illegal nibble
// (> 9) is stored as 0. freeze_i suppresses the count step, which the top
// level uses to block the step when the whole counter saturates.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       ci_i,
    input  logic       up_i,
    input  logic       freeze_i,
    output bcd_digit_t digit_o,
    output logic       co_comb_o
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    logic       at_limit;

    // Limit detection for the current direction and next digit value selection.
    always_comb begin
        digit_d  = digit_q;
        at_limit = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);

        if (load_i) begin
            digit_d = is_bcd(load_val_i) ? load_val_i : BCD_MIN;
        end else if (ci_i && !freeze_i) begin
            if (!is_bcd(digit_q)) begin
                // Unreachable after reset; fall back to a legal digit.
                digit_d = BCD_MIN;
            end else if (up_i) begin
                digit_d = at_limit ? BCD_MIN : (digit_q + 4'd1);
            end else begin
                digit_d = at_limit ? BCD_MAX : (digit_q - 4'd1);
            end
        end
    end

    // Digit state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o   = digit_q;
    assign co_comb_o = ci_i && at_limit;

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with synchronous parallel load, ripple
// carry/borrow between digits, a one-cycle carry/borrow pulse (co) and a
// one-cycle illegal-load pulse (load_err).
// Build option: define BCD_COUNTER_SATURATE_EN to stop at all-9s / all-0s
// instead of wrapping; co still pulses on every blocked step.
// Priority at each clock edge: reset > load > count > hold.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  co,
    output logic                  load_err
);

    // carry[k] is the carry/borrow into digit k; carry[DIGITS] means the
    // whole counter is at its limit with an enabled step, i.e. wrap/overflow.
    logic [DIGITS:0] carry;
    logic            freeze;
    logic            din_bad;
    logic            co_d;
    logic            co_q;
    logic            load_err_d;
    logic            load_err_q;

    assign carry[0] = en;

`ifdef BCD_COUNTER_SATURATE_EN
    assign freeze = carry[DIGITS];
`else
    assign freeze = 1'b0;
`endif

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .clk_i      (clk),
                .rst_ni     (reset),
                .load_i     (load),
                .load_val_i (din[4*k +: 4]),
                .ci_i       (carry[k]),
                .up_i       (up),
                .freeze_i   (freeze),
                .digit_o    (bcd_out[4*k +: 4]),
                .co_comb_o  (carry[k+1])
            );
        end
    endgenerate

    // Flag any load nibble outside 0..9 and form the next pulse values.
    always_comb begin
        din_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(din[4*i +: 4])) begin
                din_bad = 1'b1;
            end
        end
        co_d       = !load && carry[DIGITS];
        load_err_d = load && din_bad;
    end

    // Pulse registers for carry/borrow and illegal load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            co_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            co_q       <= co_d;
            load_err_q <= load_err_d;
        end
    end

    assign co       = co_q;
    assign load_err = load_err_q;

endmodule : bcd_counter_n
